pe_io_frontend: RTL

Parametrised PE I/O front-end that sits between the PE-array NoC ports and one processing element. It replaces fixed per-stream FIFOs with width-converting buffers for ifmap, filter and ipsum (wide packet to narrow pixel) and opsum (narrow pixel to wide packet). New over the previous generation: per-stream pack ratios, a valid/ready PE-side handshake, synchronous flush, zero-padded partial opsum commit, a clock-enable and a busy summary.

---
 rtl/pe_io_pkg.sv | 35 +++
 rtl/pe_pack_fifo.sv | 150 +++++++++++++++
 rtl/pe_io_frontend.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pe_io_pkg.sv
// pe_io_pkg: shared widths, direction enum and error bit map
// for the PE I/O front-end and its width-converting FIFOs.
package pe_io_pkg;

    typedef enum logic {
        DIR_UNPACK = 1'b0,
        DIR_PACK   = 1'b1
    } pack_dir_e;

    localparam int ERR_IFMAP  = 0;
    localparam int ERR_FILTER = 1;
    localparam int ERR_IPSUM  = 2;
    localparam int ERR_OPSUM  = 3;
    localparam int ERR_W      = 4;

    localparam int MIN_PACK = 1;
    localparam int MAX_PACK = 16;

    function automatic int lane_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit pack_ok(input int pack);
        return (pack >= MIN_PACK) && (pack <= MAX_PACK);
    endfunction

endpackage

// File: rtl/pe_pack_fifo.sv
// pe_pack_fifo: packet FIFO with a pixel-side lane converter.
// DIR_UNPACK: pkt_in/pkt_push -> pix_out/pix_out_valid/pix_out_ready.
// DIR_PACK:   pix_in/pix_in_valid/pix_in_last/pix_in_ready -> pkt_out/pkt_pop.
// Common: clk, reset (sync, high), enable, flush, full, empty, count,
// partial (lane counter non-zero).
module pe_pack_fifo
    import pe_io_pkg::*;
#(
    parameter int        DATA_WIDTH = 16,
    parameter int        PACK       = 4,
    parameter int        DEPTH      = 8,
    parameter pack_dir_e DIR        = DIR_UNPACK,
    localparam int       PW         = PACK * DATA_WIDTH,
    localparam int       CW         = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [PW-1:0]         pkt_in,
    input  logic                  pkt_push,
    output logic [PW-1:0]         pkt_out,
    input  logic                  pkt_pop,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_in_valid,
    input  logic                  pix_in_last,
    output logic                  pix_in_ready,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic                  pix_out_valid,
    input  logic                  pix_out_ready,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic                  partial
);

    localparam int LW = lane_w(PACK);
    localparam int AW = ptr_w(DEPTH);
    localparam logic [LW-1:0] LANE_LAST = LW'(PACK - 1);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [LW-1:0] lane;

    logic          do_wr;
    logic          do_rd;
    logic          step;
    logic          lane_wrap;
    logic [PW-1:0] wr_data;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign partial = (lane != '0);

    if (DIR == DIR_UNPACK) begin : g_unpack
        logic [PACK-1:0][DATA_WIDTH-1:0] head;
        logic                            xfer;
        logic                            unused_in;

        assign head = mem[rd_ptr];

        always_comb begin
            pix_out = '0;
            for (int i = 0; i < PACK; i++) begin
                if (LW'(i) == lane) pix_out = head[i];
            end
        end

        assign xfer      = ~empty & pix_out_ready & enable & ~flush;
        assign step      = xfer;
        assign lane_wrap = (lane == LANE_LAST);
        assign do_rd     = xfer & lane_wrap;
        assign do_wr     = pkt_push & ~full & enable & ~flush;
        assign wr_data   = pkt_in;

        assign pix_out_valid = ~empty;
        assign pix_in_ready  = 1'b0;
        assign pkt_out       = '0;
        assign unused_in = ^{pkt_pop, pix_in, pix_in_valid, pix_in_last};
    end else begin : g_pack
        logic [PACK-1:0][DATA_WIDTH-1:0] pack_reg;
        logic [PACK-1:0][DATA_WIDTH-1:0] pack_nxt;
        logic                            accept;
        logic                            unused_in;

        // Lanes above the current one stay zero because the register
        // is cleared on every commit, which gives the zero padding.
        always_comb begin
            pack_nxt = pack_reg;
            for (int i = 0; i < PACK; i++) begin
                if (LW'(i) == lane) pack_nxt[i] = pix_in;
            end
        end

        assign accept    = pix_in_valid & ~full & enable & ~flush;
        assign step      = accept;
        assign lane_wrap = (lane == LANE_LAST) | pix_in_last;
        assign do_wr     = accept & lane_wrap;
        assign wr_data   = pack_nxt;
        assign do_rd     = pkt_pop & ~empty & enable & ~flush;

        always_ff @(posedge clk) begin
            if (reset) begin
                pack_reg <= '0;
            end else if (enable) begin
                if (flush) pack_reg <= '0;
                else if (accept) pack_reg <= lane_wrap ? '0 : pack_nxt;
            end
        end

        assign pkt_out       = mem[rd_ptr];
        assign pix_in_ready  = ~full;
        assign pix_out       = '0;
        assign pix_out_valid = 1'b0;
        assign unused_in = ^{pkt_in, pkt_push, pix_out_ready};
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            lane   <= '0;
        end else if (enable) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                lane   <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + AW'(1);
                if (do_rd) rd_ptr <= rd_ptr + AW'(1);
                unique case ({do_wr, do_rd})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
                if (step) lane <= lane_wrap ? '0 : lane + LW'(1);
            end
        end
    end

endmodule

// File: rtl/pe_io_frontend.sv
// pe_io_frontend: NoC <-> PE width-converting buffers (ifmap/filter/
// ipsum unpack, opsum pack), flush fan-out, busy and afull summary.
// Ports: clk, reset, enable, flush, busy; ifmap/filter/ipsum packet push
// with *_fifo_full; opsum packet pop with opsum_fifo_empty; PE-side
// *_pixel/*_valid/*_ready streams; opsum_last, opsum_afull.
// Optional PE_IO_ERR_EN adds sticky err[3:0] (ifmap, filter, ipsum, opsum-pop).
module pe_io_frontend
    import pe_io_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int IFMAP_PACK         = 1,
    parameter int FILTER_PACK        = 4,
    parameter int PSUM_PACK          = 4,
    parameter int IFMAP_DEPTH        = 8,
    parameter int FILTER_DEPTH       = 8,
    parameter int PSUM_DEPTH         = 8,
    parameter int OPSUM_AFULL_MARGIN = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              flush,
    output logic                              busy,
`ifdef PE_IO_ERR_EN
    output logic [ERR_W-1:0]                  err,
`endif
    input  logic [IFMAP_PACK*DATA_WIDTH-1:0]  ifmap,
    input  logic                              push_ifmap,
    output logic                              ifmap_fifo_full,
    input  logic [FILTER_PACK*DATA_WIDTH-1:0] filter,
    input  logic                              push_filter,
    output logic                              filter_fifo_full,
    input  logic [PSUM_PACK*DATA_WIDTH-1:0]   ipsum,
    input  logic                              push_ipsum,
    output logic                              ipsum_fifo_full,
    output logic [PSUM_PACK*DATA_WIDTH-1:0]   opsum,
    input  logic                              pop_opsum,
    output logic                              opsum_fifo_empty,
    output logic [DATA_WIDTH-1:0]             ifmap_pixel,
    output logic                              ifmap_valid,
    input  logic                              ifmap_ready,
    output logic [DATA_WIDTH-1:0]             filter_pixel,
    output logic                              filter_valid,
    input  logic                              filter_ready,
    output logic [DATA_WIDTH-1:0]             ipsum_pixel,
    output logic                              ipsum_valid,
    input  logic                              ipsum_ready,
    input  logic [DATA_WIDTH-1:0]             opsum_pixel,
    input  logic                              opsum_valid,
    input  logic                              opsum_last,
    output logic                              opsum_ready,
    output logic                              opsum_afull
);

    localparam int IPW = IFMAP_PACK * DATA_WIDTH;
    localparam int FPW = FILTER_PACK * DATA_WIDTH;
    localparam int PPW = PSUM_PACK * DATA_WIDTH;
    localparam int ICW = cnt_w(IFMAP_DEPTH);
    localparam int FCW = cnt_w(FILTER_DEPTH);
    localparam int PCW = cnt_w(PSUM_DEPTH);

    logic           ifm_empty, flt_empty, ips_empty;
    logic           ops_partial;
    logic [PCW-1:0] ops_count;

    logic [IPW-1:0] ifm_pkt_nc;
    logic [FPW-1:0] flt_pkt_nc;
    logic [PPW-1:0] ips_pkt_nc;
    logic [ICW-1:0] ifm_cnt_nc;
    logic [FCW-1:0] flt_cnt_nc;
    logic [PCW-1:0] ips_cnt_nc;
    logic           ifm_rdy_nc, flt_rdy_nc, ips_rdy_nc;
    logic           ifm_part_nc, flt_part_nc, ips_part_nc;
    logic [DATA_WIDTH-1:0] ops_pix_nc;
    logic           ops_vld_nc, ops_full_nc;
    logic           unused_nc;

    pe_pack_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .PACK(IFMAP_PACK),
        .DEPTH(IFMAP_DEPTH), .DIR(DIR_UNPACK)
    ) u_ifmap (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .pkt_in(ifmap), .pkt_push(push_ifmap),
        .pkt_out(ifm_pkt_nc), .pkt_pop(1'b0),
        .pix_in('0), .pix_in_valid(1'b0), .pix_in_last(1'b0),
        .pix_in_ready(ifm_rdy_nc),
        .pix_out(ifmap_pixel), .pix_out_valid(ifmap_valid),
        .pix_out_ready(ifmap_ready),
        .full(ifmap_fifo_full), .empty(ifm_empty),
        .count(ifm_cnt_nc), .partial(ifm_part_nc)
    );

    pe_pack_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .PACK(FILTER_PACK),
        .DEPTH(FILTER_DEPTH), .DIR(DIR_UNPACK)
    ) u_filter (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .pkt_in(filter), .pkt_push(push_filter),
        .pkt_out(flt_pkt_nc), .pkt_pop(1'b0),
        .pix_in('0), .pix_in_valid(1'b0), .pix_in_last(1'b0),
        .pix_in_ready(flt_rdy_nc),
        .pix_out(filter_pixel), .pix_out_valid(filter_valid),
        .pix_out_ready(filter_ready),
        .full(filter_fifo_full), .empty(flt_empty),
        .count(flt_cnt_nc), .partial(flt_part_nc)
    );

    pe_pack_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .PACK(PSUM_PACK),
        .DEPTH(PSUM_DEPTH), .DIR(DIR_UNPACK)
    ) u_ipsum (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .pkt_in(ipsum), .pkt_push(push_ipsum),
        .pkt_out(ips_pkt_nc), .pkt_pop(1'b0),
        .pix_in('0), .pix_in_valid(1'b0), .pix_in_last(1'b0),
        .pix_in_ready(ips_rdy_nc),
        .pix_out(ipsum_pixel), .pix_out_valid(ipsum_valid),
        .pix_out_ready(ipsum_ready),
        .full(ipsum_fifo_full), .empty(ips_empty),
        .count(ips_cnt_nc), .partial(ips_part_nc)
    );

    pe_pack_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .PACK(PSUM_PACK),
        .DEPTH(PSUM_DEPTH), .DIR(DIR_PACK)
    ) u_opsum (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .pkt_in('0), .pkt_push(1'b0),
        .pkt_out(opsum), .pkt_pop(pop_opsum),
        .pix_in(opsum_pixel), .pix_in_valid(opsum_valid),
        .pix_in_last(opsum_last), .pix_in_ready(opsum_ready),
        .pix_out(ops_pix_nc), .pix_out_valid(ops_vld_nc),
        .pix_out_ready(1'b0),
        .full(ops_full_nc), .empty(opsum_fifo_empty),
        .count(ops_count), .partial(ops_partial)
    );

    // A half-built opsum packet counts as work in flight.
    assign busy = ~ifm_empty | ~flt_empty | ~ips_empty
                | ~opsum_fifo_empty | ops_partial;

    assign opsum_afull =
        (PSUM_DEPTH - int'(ops_count)) <= OPSUM_AFULL_MARGIN;

    assign unused_nc = ^{ifm_pkt_nc, flt_pkt_nc, ips_pkt_nc,
                         ifm_cnt_nc, flt_cnt_nc, ips_cnt_nc,
                         ifm_rdy_nc, flt_rdy_nc, ips_rdy_nc,
                         ifm_part_nc, flt_part_nc, ips_part_nc,
                         ops_pix_nc, ops_vld_nc, ops_full_nc};

`ifdef PE_IO_ERR_EN
    logic [ERR_W-1:0] err_set;

    assign err_set[ERR_IFMAP]  = push_ifmap  & ifmap_fifo_full  & enable;
    assign err_set[ERR_FILTER] = push_filter & filter_fifo_full & enable;
    assign err_set[ERR_IPSUM]  = push_ipsum  & ipsum_fifo_full  & enable;
    assign err_set[ERR_OPSUM]  = pop_opsum   & opsum_fifo_empty & enable;

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) err <= '0;
        else       err <= err | err_set;
    end
`endif

endmodule
